mux_scan: RTL and testbench

- Parametrised, registered N-channel, W-bit selector. Generalises the gate-level 2:1 mux to CHANNELS inputs of WIDTH bits.
- Adds a selection register with four modes: manual load, push-button step, auto-scan on a prescaled tick, and hold.
- Sits between board switches/buses and LED/HEX display logic. Scans or picks one source for display.

---
 rtl/mux_scan.sv | 170 +++++++++++++++++
 tb/tb_mux_scan.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan
// Purpose  : Registered CHANNELS x WIDTH selector. The selection is loaded,
//            stepped by a key, auto-scanned on a prescaled tick, or held.
//            Optional macro MUX_SCAN_SKIP_EN: advances and loads skip
//            channels whose mask bit is clear.
// Revision : 1.0 - initial release
// ============================================================================
module mux_scan #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int DIV      = 25000000,
    localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [1:0]                mode,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic                      load,
    input  logic                      step,
    input  logic [CHANNELS-1:0]       mask,
    output logic [WIDTH-1:0]          data_out,
    output logic [SEL_W-1:0]          sel_out,
    output logic                      tick
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [1:0]       c_MODE_MANUAL = 2'b00;
    localparam logic [1:0]       c_MODE_STEP   = 2'b01;
    localparam logic [1:0]       c_MODE_AUTO   = 2'b10;
    localparam logic [1:0]       c_MODE_HOLD   = 2'b11;
    localparam logic [SEL_W-1:0] c_SEL_LAST    = SEL_W'(CHANNELS - 1);
    localparam logic [PW-1:0]    c_DIV_LAST    = PW'(DIV - 1);

    logic [SEL_W-1:0] r_sel;
    logic [WIDTH-1:0] r_data;
    logic             r_tick;
    logic             r_step_q;
    logic [PW-1:0]    r_presc;
    logic [1:0]       r_mode_q;

    logic [SEL_W-1:0] w_sel_next;
    logic [SEL_W-1:0] w_sel_inc;
    logic [SEL_W-1:0] w_adv_sel;
    logic             w_adv_tick;
    logic [WIDTH-1:0] w_data_next;
    logic             w_tick_next;
    logic [PW-1:0]    w_presc_cur;
    logic [PW-1:0]    w_presc_next;
    logic             w_step_rise;
    logic             w_sel_in_legal;
    logic             w_sel_in_en;
    logic             w_load_ok;
    logic             w_auto_wrap;

    assign w_sel_inc   = (r_sel == c_SEL_LAST) ? '0 : r_sel + 1'b1;
    assign w_step_rise = step & ~r_step_q;
    // The prescaler restarts whenever AUTO is (re)entered from another mode.
    assign w_presc_cur = (r_mode_q == c_MODE_AUTO) ? r_presc : '0;
    assign w_auto_wrap = (w_presc_cur == c_DIV_LAST);

    // Equality scan keeps the range check valid for non power-of-two counts.
    always_comb begin
        w_sel_in_legal = 1'b0;
        w_sel_in_en    = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel_in == SEL_W'(k)) begin
                w_sel_in_legal = 1'b1;
                w_sel_in_en    = mask[k];
            end
        end
    end

`ifdef MUX_SCAN_SKIP_EN
    logic             w_above_found;
    logic             w_below_found;
    logic [SEL_W-1:0] w_above_sel;
    logic [SEL_W-1:0] w_below_sel;

    // Nearest enabled channel above sel, else the lowest enabled one below.
    always_comb begin
        w_above_found = 1'b0;
        w_below_found = 1'b0;
        w_above_sel   = '0;
        w_below_sel   = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (mask[k] && (SEL_W'(k) > r_sel)) begin
                w_above_found = 1'b1;
                w_above_sel   = SEL_W'(k);
            end
            if (mask[k] && (SEL_W'(k) < r_sel)) begin
                w_below_found = 1'b1;
                w_below_sel   = SEL_W'(k);
            end
        end
    end

    assign w_adv_sel  = w_above_found ? w_above_sel :
                        w_below_found ? w_below_sel : r_sel;
    assign w_adv_tick = |mask;
    assign w_load_ok  = load & w_sel_in_legal & w_sel_in_en;
`else
    logic w_mask_unused;

    assign w_mask_unused = ^{mask, w_sel_in_en};
    assign w_adv_sel     = w_sel_inc;
    assign w_adv_tick    = 1'b1;
    assign w_load_ok     = load & w_sel_in_legal;
`endif

    always_comb begin
        w_sel_next   = r_sel;
        w_tick_next  = 1'b0;
        w_presc_next = r_presc;
        if (mode != c_MODE_HOLD) begin
            if (mode == c_MODE_AUTO) begin
                w_presc_next = w_auto_wrap ? '0 : w_presc_cur + 1'b1;
            end else begin
                w_presc_next = '0;
            end

            if (w_load_ok) begin
                w_sel_next   = sel_in;
                w_presc_next = '0;
            end else if (((mode == c_MODE_STEP) && w_step_rise) ||
                         ((mode == c_MODE_AUTO) && w_auto_wrap)) begin
                w_sel_next  = w_adv_sel;
                w_tick_next = w_adv_tick;
            end
        end
    end

    always_comb begin
        w_data_next = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_sel_next == SEL_W'(k)) begin
                w_data_next = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sel    <= '0;
            r_data   <= '0;
            r_tick   <= 1'b0;
            r_step_q <= 1'b0;
            r_presc  <= '0;
            r_mode_q <= c_MODE_MANUAL;
        end else begin
            r_step_q <= step;
            r_mode_q <= mode;
            r_sel    <= w_sel_next;
            r_presc  <= w_presc_next;
            r_tick   <= w_tick_next;
            if (mode != c_MODE_HOLD) begin
                r_data <= w_data_next;
            end
        end
    end

    assign data_out = r_data;
    assign sel_out  = r_sel;
    assign tick     = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_scan
// Purpose  : Directed bench for mux_scan with a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_scan;

    localparam int CH  = 4;
    localparam int DIV = 3;

    logic        clock = 1'b0;
    logic        resetn;
    logic [15:0] data_in;
    logic [1:0]  mode;
    logic [1:0]  sel_in;
    logic        load;
    logic        step;
    logic [3:0]  mask;
    logic [3:0]  data_out;
    logic [1:0]  sel_out;
    logic        tick;

    logic [11:0] data_in3;
    logic [2:0]  mask3;
    logic [3:0]  data_out3;
    logic [1:0]  sel_out3;
    logic        tick3;

    always #5 clock = ~clock;

    mux_scan #(.WIDTH(4), .CHANNELS(4), .DIV(DIV)) u_dut (
        .clock(clock), .resetn(resetn), .data_in(data_in), .mode(mode),
        .sel_in(sel_in), .load(load), .step(step), .mask(mask),
        .data_out(data_out), .sel_out(sel_out), .tick(tick)
    );

    mux_scan #(.WIDTH(4), .CHANNELS(3), .DIV(DIV)) u_dut3 (
        .clock(clock), .resetn(resetn), .data_in(data_in3), .mode(mode),
        .sel_in(sel_in), .load(load), .step(step), .mask(mask3),
        .data_out(data_out3), .sel_out(sel_out3), .tick(tick3)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_sel       = 0;
    logic [3:0] m_data      = '0;
    logic       m_tick      = 1'b0;
    int         m_cnt       = 0;
    bit         m_in_auto   = 1'b0;
    logic       m_prev_step = 1'b0;

    function automatic int next_sel(input int s);
`ifdef MUX_SCAN_SKIP_EN
        for (int i = 1; i < CH; i++) begin
            if (mask[(s + i) % CH]) return (s + i) % CH;
        end
        return s;
`else
        return (s + 1) % CH;
`endif
    endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_sel = 0; m_data = '0; m_tick = 1'b0;
            m_cnt = 0; m_in_auto = 1'b0; m_prev_step = 1'b0;
        end else begin
            bit ld;
            bit adv;
            adv    = 1'b0;
            m_tick = 1'b0;
            ld     = load && (int'(sel_in) < CH);
`ifdef MUX_SCAN_SKIP_EN
            ld = ld && mask[sel_in];
`endif
            if (mode != 2'b11) begin
                if (mode == 2'b10) begin
                    if (!m_in_auto) m_cnt = 0;
                    m_in_auto = 1'b1;
                    m_cnt++;
                end else begin
                    m_in_auto = 1'b0;
                end
                if (ld) begin
                    m_sel = int'(sel_in);
                    m_cnt = 0;
                end else if (mode == 2'b01 && step && !m_prev_step) begin
                    adv = 1'b1;
                end else if (mode == 2'b10 && m_cnt == DIV) begin
                    adv = 1'b1;
                end
                if (m_cnt == DIV) m_cnt = 0;
                if (adv) begin
`ifdef MUX_SCAN_SKIP_EN
                    m_tick = |mask;
`else
                    m_tick = 1'b1;
`endif
                    m_sel = next_sel(m_sel);
                end
                m_data = data_in[m_sel*4 +: 4];
            end else begin
                m_in_auto = 1'b0;
            end
            m_prev_step = step;
        end
    end

    always @(negedge clock) begin
        chk("model_data_out", 32'(data_out), 32'(m_data));
        chk("model_sel_out", 32'(sel_out), 32'(m_sel));
        chk("model_tick", 32'(tick), 32'(m_tick));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    int ticks;
    int n;
    int tsel[$];
    int tpos[$];
    int exp_seq[5];
    int exp_pos[5];

    initial begin
        exp_seq = '{1, 2, 3, 0, 1};
        exp_pos = '{2, 5, 8, 11, 14};
        resetn = 1'b0; mode = 2'b00; data_in = 16'hDCBA; data_in3 = 12'hCBA;
        load = 1'b0; step = 1'b0; sel_in = 2'd0; mask = 4'hF; mask3 = 3'h7;
        repeat (2) @(negedge clock);
        chk("reset_data", 32'(data_out), 32'h0);
        chk("reset_sel", 32'(sel_out), 32'h0);
        chk("reset_tick", 32'(tick), 32'h0);
        resetn = 1'b1;
        @(negedge clock);
        chk("release_data", 32'(data_out), 32'hA);

        // manual load, including an out-of-range index on the 3-channel unit
        sel_in = 2'd2; load = 1'b1;
        @(negedge clock);
        chk("load2_sel", 32'(sel_out), 32'd2);
        chk("load2_data", 32'(data_out), 32'hC);
        chk("load2_tick", 32'(tick), 32'd0);
        chk("load2_sel3", 32'(sel_out3), 32'd2);
        sel_in = 2'd3;
        @(negedge clock);
        chk("load3_sel", 32'(sel_out), 32'd3);
        chk("load3_data", 32'(data_out), 32'hD);
        chk("illegal_sel3", 32'(sel_out3), 32'd2);
        chk("illegal_data3", 32'(data_out3), 32'hC);
        chk("illegal_tick3", 32'(tick3), 32'd0);
        load = 1'b0;

        // step held high: one advance only
        mode = 2'b01; step = 1'b1; ticks = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            ticks += int'(tick);
            if (i == 0) chk("wrap_sel3", 32'(sel_out3), 32'd0);
        end
        chk("step_ticks", 32'(ticks), 32'd1);
        chk("step_sel", 32'(sel_out), 32'd0);
        chk("step_data", 32'(data_out), 32'hA);
        step = 1'b0;
        @(negedge clock);
        step = 1'b1;
        @(negedge clock);
        chk("step2_sel", 32'(sel_out), 32'd1);
        chk("step2_data", 32'(data_out), 32'hB);
        step = 1'b0;

        // auto scan from channel 0
        mode = 2'b00; sel_in = 2'd0; load = 1'b1;
        @(negedge clock);
        load = 1'b0; mode = 2'b10;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            if (tick) begin
                tsel.push_back(int'(sel_out));
                tpos.push_back(i);
            end
        end
        chk("auto_tick_count", 32'(tsel.size()), 32'd5);
        for (int i = 0; i < 5 && i < tsel.size(); i++) begin
            chk("auto_seq", 32'(tsel[i]), 32'(exp_seq[i]));
            chk("auto_pos", 32'(tpos[i]), 32'(exp_pos[i]));
        end
        @(negedge clock);
        mode = 2'b11; data_in = 16'h1234;
        repeat (3) @(negedge clock);
        chk("hold_data", 32'(data_out), 32'hB);
        chk("hold_sel", 32'(sel_out), 32'd1);
        chk("hold_tick", 32'(tick), 32'd0);
        mode = 2'b10; n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!tick && n < 10);
        chk("reentry_latency", 32'(n), 32'd3);
        chk("reentry_data", 32'(data_out), 32'h2);

        // load coincident with the auto advance wins
        repeat (2) @(negedge clock);
        sel_in = 2'd0; load = 1'b1;
        @(negedge clock);
        chk("coinc_sel", 32'(sel_out), 32'd0);
        chk("coinc_tick", 32'(tick), 32'd0);
        chk("coinc_data", 32'(data_out), 32'h4);
        load = 1'b0; n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!tick && n < 10);
        chk("coinc_restart", 32'(n), 32'd3);
        chk("coinc_next_sel", 32'(sel_out), 32'd1);

        // asynchronous reset between edges
        @(posedge clock);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_data", 32'(data_out), 32'h0);
        chk("async_rst_sel", 32'(sel_out), 32'h0);
        chk("async_rst_tick", 32'(tick), 32'h0);
        @(negedge clock);
        resetn = 1'b1; mode = 2'b00;
        @(negedge clock);

`ifdef MUX_SCAN_SKIP_EN
        mask = 4'b1010; sel_in = 2'd1; load = 1'b1;
        @(negedge clock);
        chk("skip_load_sel", 32'(sel_out), 32'd1);
        load = 1'b0; mode = 2'b10;
        tsel.delete();
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            if (tick) tsel.push_back(int'(sel_out));
        end
        chk("skip_count", 32'(tsel.size()), 32'd3);
        if (tsel.size() == 3) begin
            chk("skip_seq0", 32'(tsel[0]), 32'd3);
            chk("skip_seq1", 32'(tsel[1]), 32'd1);
            chk("skip_seq2", 32'(tsel[2]), 32'd3);
        end
        mask = 4'b0000; ticks = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            ticks += int'(tick);
        end
        chk("skip_zero_ticks", 32'(ticks), 32'd0);
        chk("skip_zero_sel", 32'(sel_out), 32'd3);
        mode = 2'b00; mask = 4'b1010; sel_in = 2'd0; load = 1'b1;
        @(negedge clock);
        chk("skip_masked_load", 32'(sel_out), 32'd3);
        load = 1'b0;
`endif

        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
